csr_trap_ctrl: RTL

- Sequencer and arbiter for the single-port machine-mode CSR file. The CSR file has one address (A1), one write enable (RFWr) and one combinational read port (RD1), and writes on negedge clk.
- Shares that port between the datapath's CSR instructions and the trap/MRET hardware.
- On a trap it performs the multi-cycle CSR update and computes the redirect PC. On MRET it restores mstatus and returns mepc.
- Sits between the decode/execute stage and the CSR instance.

---
 rtl/csr_trap_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/csr_trap_ctrl.sv
// Trap/MRET sequencer and arbiter for the single-port machine-mode CSR file.
// Build option: define CSR_TRAP_VECTORED_EN to honour vectored mtvec mode for interrupts.
module csr_trap_ctrl #(
   parameter int XLEN   = 32,
   parameter int CSR_AW = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inst_we,
   input  logic [CSR_AW-1:0] inst_addr,
   input  logic [XLEN-1:0]   inst_wdata,
   output logic [XLEN-1:0]   inst_rdata,
   input  logic              trap_req,
   input  logic [XLEN-1:0]   trap_cause,
   input  logic [XLEN-1:0]   trap_pc,
   input  logic [XLEN-1:0]   trap_tval,
   input  logic              mret_req,
   output logic              trap_ack,
   output logic              mret_ack,
   output logic              busy,
   output logic              redirect_valid,
   output logic [XLEN-1:0]   redirect_pc,
   output logic              csr_we,
   output logic [CSR_AW-1:0] csr_addr,
   output logic [XLEN-1:0]   csr_wdata,
   input  logic [XLEN-1:0]   csr_rdata
);

   localparam logic [CSR_AW-1:0] ADDR_MSTATUS = CSR_AW'(12'h300);
   localparam logic [CSR_AW-1:0] ADDR_MTVEC   = CSR_AW'(12'h305);
   localparam logic [CSR_AW-1:0] ADDR_MEPC    = CSR_AW'(12'h341);
   localparam logic [CSR_AW-1:0] ADDR_MCAUSE  = CSR_AW'(12'h342);
   localparam logic [CSR_AW-1:0] ADDR_MTVAL   = CSR_AW'(12'h343);

   typedef enum logic [2:0] {
      IDLE, T_EPC, T_CAUSE, T_TVAL, T_STAT, T_VEC, M_STAT, M_EPC
   } state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] cause_q, cause_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] tval_q, tval_d;
   logic            redirect_valid_q, redirect_valid_d;
   logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

   // Interrupts in vectored mode jump to base + 4*cause; everything else to base.
   function automatic logic [XLEN-1:0] trap_target(input logic [XLEN-1:0] mtvec,
                                                   input logic [XLEN-1:0] cause);
      logic [XLEN-1:0] base;
      base = {mtvec[XLEN-1:2], 2'b00};
`ifdef CSR_TRAP_VECTORED_EN
      if ((mtvec[1:0] == 2'b01) && cause[XLEN-1]) begin
         trap_target = base + {cause[XLEN-3:0], 2'b00};
      end else begin
         trap_target = base;
      end
`else
      trap_target = base;
`endif
   endfunction

   assign inst_rdata     = csr_rdata;
   assign busy           = (state_q != IDLE) | trap_req | mret_req;
   assign redirect_valid = redirect_valid_q;
   assign redirect_pc    = redirect_pc_q;

   // Next-state logic and CSR port mux, both decoded from the current state.
   always_comb begin
      state_d          = state_q;
      cause_d          = cause_q;
      pc_d             = pc_q;
      tval_d           = tval_q;
      redirect_valid_d = 1'b0;
      redirect_pc_d    = redirect_pc_q;
      trap_ack         = 1'b0;
      mret_ack         = 1'b0;
      csr_we           = 1'b0;
      csr_addr         = ADDR_MSTATUS;
      csr_wdata        = csr_rdata;
      case (state_q)
         IDLE: begin
            if (trap_req) begin
               cause_d  = trap_cause;
               pc_d     = trap_pc;
               tval_d   = trap_tval;
               trap_ack = 1'b1;
               state_d  = T_EPC;
            end else if (mret_req) begin
               mret_ack = 1'b1;
               state_d  = M_STAT;
            end else begin
               csr_we    = inst_we;
               csr_addr  = inst_addr;
               csr_wdata = inst_wdata;
            end
         end
         T_EPC: begin
            csr_we    = 1'b1;
            csr_addr  = ADDR_MEPC;
            csr_wdata = pc_q;
            state_d   = T_CAUSE;
         end
         T_CAUSE: begin
            csr_we    = 1'b1;
            csr_addr  = ADDR_MCAUSE;
            csr_wdata = cause_q;
            state_d   = T_TVAL;
         end
         T_TVAL: begin
            csr_we    = 1'b1;
            csr_addr  = ADDR_MTVAL;
            csr_wdata = tval_q;
            state_d   = T_STAT;
         end
         T_STAT: begin
            csr_we       = 1'b1;
            csr_addr     = ADDR_MSTATUS;
            csr_wdata    = csr_rdata;
            csr_wdata[7] = csr_rdata[3];
            csr_wdata[3] = 1'b0;
            state_d      = T_VEC;
         end
         T_VEC: begin
            csr_addr         = ADDR_MTVEC;
            redirect_pc_d    = trap_target(csr_rdata, cause_q);
            redirect_valid_d = 1'b1;
            state_d          = IDLE;
         end
         M_STAT: begin
            csr_we       = 1'b1;
            csr_addr     = ADDR_MSTATUS;
            csr_wdata    = csr_rdata;
            csr_wdata[3] = csr_rdata[7];
            csr_wdata[7] = 1'b1;
            state_d      = M_EPC;
         end
         M_EPC: begin
            csr_addr         = ADDR_MEPC;
            redirect_pc_d    = csr_rdata;
            redirect_valid_d = 1'b1;
            state_d          = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, latched trap operands and the registered redirect.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q          <= IDLE;
         cause_q          <= '0;
         pc_q             <= '0;
         tval_q           <= '0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
      end else begin
         state_q          <= state_d;
         cause_q          <= cause_d;
         pc_q             <= pc_d;
         tval_q           <= tval_d;
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
      end
   end

endmodule
